// File: rtl/baccarat_pkg.sv
// Shared card codes, seven-segment patterns, slot enumeration and hand scoring
// for the Baccarat datapath.
package baccarat_pkg;

  localparam logic [3:0] CARD_EMPTY = 4'd0;
  localparam logic [3:0] CARD_ACE   = 4'd1;
  localparam logic [3:0] CARD_TEN   = 4'd10;
  localparam logic [3:0] CARD_JACK  = 4'd11;
  localparam logic [3:0] CARD_QUEEN = 4'd12;
  localparam logic [3:0] CARD_KING  = 4'd13;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_EMPTY = 7'b1111111;
  localparam logic [6:0] SEG_ACE   = 7'b0001000;
  localparam logic [6:0] SEG_TWO   = 7'b0100100;
  localparam logic [6:0] SEG_THREE = 7'b0110000;
  localparam logic [6:0] SEG_FOUR  = 7'b0011001;
  localparam logic [6:0] SEG_FIVE  = 7'b0010010;
  localparam logic [6:0] SEG_SIX   = 7'b0000010;
  localparam logic [6:0] SEG_SEVEN = 7'b1111000;
  localparam logic [6:0] SEG_EIGHT = 7'b0000000;
  localparam logic [6:0] SEG_NINE  = 7'b0010000;
  localparam logic [6:0] SEG_TEN   = 7'b1000000;
  localparam logic [6:0] SEG_JACK  = 7'b1100001;
  localparam logic [6:0] SEG_QUEEN = 7'b0011000;
  localparam logic [6:0] SEG_KING  = 7'b0001001;

  typedef enum logic [2:0] {
    SLOT_P1 = 3'd0,
    SLOT_P2 = 3'd1,
    SLOT_P3 = 3'd2,
    SLOT_D1 = 3'd3,
    SLOT_D2 = 3'd4,
    SLOT_D3 = 3'd5
  } card_slot_e;

  localparam int NUM_SLOTS = 6;

  // Only pip cards count; empty, ten, faces and invalid codes score zero
  function automatic logic [3:0] card_value(input logic [3:0] code);
    return (code >= 4'd1 && code <= 4'd9) ? code : 4'd0;
  endfunction

  function automatic logic [3:0] hand_score(input logic [3:0] c1,
                                            input logic [3:0] c2,
                                            input logic [3:0] c3);
    logic [4:0] sum;
    sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    if (sum >= 5'd20)
      sum = sum - 5'd20;
    else if (sum >= 5'd10)
      sum = sum - 5'd10;
    return sum[3:0];
  endfunction

endpackage

// File: rtl/card7seg.sv
// Card code to active-low seven-segment pattern; unused codes show blank.
module card7seg
  import baccarat_pkg::*;
(
  input  logic [3:0] card,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_EMPTY;
    case (card)
      CARD_ACE:   seg = SEG_ACE;
      4'd2:       seg = SEG_TWO;
      4'd3:       seg = SEG_THREE;
      4'd4:       seg = SEG_FOUR;
      4'd5:       seg = SEG_FIVE;
      4'd6:       seg = SEG_SIX;
      4'd7:       seg = SEG_SEVEN;
      4'd8:       seg = SEG_EIGHT;
      4'd9:       seg = SEG_NINE;
      CARD_TEN:   seg = SEG_TEN;
      CARD_JACK:  seg = SEG_JACK;
      CARD_QUEEN: seg = SEG_QUEEN;
      CARD_KING:  seg = SEG_KING;
      default:    seg = SEG_EMPTY;
    endcase
  end

endmodule

// File: rtl/baccarat_datapath.sv
// Baccarat card registers, hand scoring, display drive and sticky
// dealing-order checker.
module baccarat_datapath
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] new_card,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [3:0] pcard3,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       deal_error
);

  logic [3:0] cards [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] filled;
  logic [NUM_SLOTS-1:0] loads;
  logic [NUM_SLOTS-1:0] prereq_ok;
  logic one_hot;
  logic load_legal;

  always_comb begin
    loads = '0;
    loads[SLOT_P1] = load_pcard1;
    loads[SLOT_P2] = load_pcard2;
    loads[SLOT_P3] = load_pcard3;
    loads[SLOT_D1] = load_dcard1;
    loads[SLOT_D2] = load_dcard2;
    loads[SLOT_D3] = load_dcard3;
  end

  // Dealing order P1, D1, P2, D2, then P3 and D3 both hang off D2
  always_comb begin
    prereq_ok = '0;
    prereq_ok[SLOT_P1] = 1'b1;
    prereq_ok[SLOT_D1] = filled[SLOT_P1];
    prereq_ok[SLOT_P2] = filled[SLOT_D1];
    prereq_ok[SLOT_D2] = filled[SLOT_P2];
    prereq_ok[SLOT_P3] = filled[SLOT_D2];
    prereq_ok[SLOT_D3] = filled[SLOT_D2];
  end

  assign one_hot    = (loads != '0) && ((loads & (loads - 1'b1)) == '0);
  assign load_legal = one_hot && |(loads & ~filled & prereq_ok);

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        cards[i] <= CARD_EMPTY;
      filled     <= '0;
      deal_error <= 1'b0;
    end else if (loads != '0) begin
      if (load_legal) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (loads[i]) begin
            cards[i]  <= new_card;
            filled[i] <= 1'b1;
          end
        end
      end else begin
        deal_error <= 1'b1;
      end
    end
  end

  assign pscore = hand_score(cards[SLOT_P1], cards[SLOT_P2], cards[SLOT_P3]);
  assign dscore = hand_score(cards[SLOT_D1], cards[SLOT_D2], cards[SLOT_D3]);
  assign pcard3 = cards[SLOT_P3];

  card7seg u_seg_p1 (.card(cards[SLOT_P1]), .seg(HEX0));
  card7seg u_seg_p2 (.card(cards[SLOT_P2]), .seg(HEX1));
  card7seg u_seg_p3 (.card(cards[SLOT_P3]), .seg(HEX2));
  card7seg u_seg_d1 (.card(cards[SLOT_D1]), .seg(HEX3));
  card7seg u_seg_d2 (.card(cards[SLOT_D2]), .seg(HEX4));
  card7seg u_seg_d3 (.card(cards[SLOT_D3]), .seg(HEX5));

endmodule
